mux4_rr_arbiter: RTL and testbench

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter/mux with a registered valid/ready output word.
// Optional build macro MUX4_ARB_LOCK_EN adds a per-requester lock input allowing up to four consecutive grants.
module mux4_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             y_ready,
`ifdef MUX4_ARB_LOCK_EN
    input  logic [3:0]       lock,
`endif
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [3:0]       gnt,
    output logic             s1,
    output logic             s0,
    output logic [3:0]       ack
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       ptr;
    logic [1:0]       ptr_next;
    logic [1:0]       sel;
    logic [1:0]       sel_next;
    logic [WIDTH-1:0] y_next;
    logic [3:0]       gnt_next;
    logic             hs;
    logic [3:0]       cand;
    logic [1:0]       base;
    logic [1:0]       win;
`ifdef MUX4_ARB_LOCK_EN
    logic [1:0]       cnt;
    logic [1:0]       cnt_next;
    logic             relock;
`endif

    // First set bit of r searching upward from index b, wrapping modulo 4.
    function automatic logic [1:0] first_from(input logic [3:0] r, input logic [1:0] b);
        logic [1:0] idx;
        logic       found;
        first_from = b;
        found      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = b + 2'(i);
            if (!found && r[idx]) begin
                first_from = idx;
                found      = 1'b1;
            end
        end
    endfunction

    assign y_valid  = (state == BUSY);
    assign hs       = y_valid & y_ready;
    assign ack      = gnt & {4{hs}};
    assign {s1, s0} = sel;

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        sel_next   = sel;
        y_next     = y;
        gnt_next   = gnt;
        cand       = 4'b0000;
        base       = ptr;
`ifdef MUX4_ARB_LOCK_EN
        cnt_next   = cnt;
        relock     = hs && lock[sel] && req[sel] && (cnt != 2'd3);
`endif
        if (state == IDLE) begin
            cand = req;
            base = ptr;
        end else if (hs) begin
            // The word just accepted is masked so a lone requester waits a cycle.
            ptr_next = sel + 2'd1;
            cand     = req & ~ack;
            base     = sel + 2'd1;
        end
`ifdef MUX4_ARB_LOCK_EN
        if (relock) begin
            ptr_next = ptr;
            cand     = 4'b0001 << sel;
            base     = sel;
            cnt_next = cnt + 2'd1;
        end else if (hs) begin
            cnt_next = 2'd0;
        end
`endif
        win = first_from(cand, base);
        if ((state == IDLE) || hs) begin
            if (cand != 4'b0000) begin
                state_next = BUSY;
                sel_next   = win;
                gnt_next   = 4'b0001 << win;
                case (win)
                    2'd0:    y_next = i0;
                    2'd1:    y_next = i1;
                    2'd2:    y_next = i2;
                    default: y_next = i3;
                endcase
            end else if (hs) begin
                state_next = IDLE;
                gnt_next   = 4'b0000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            sel   <= 2'd0;
            y     <= '0;
            gnt   <= 4'b0000;
`ifdef MUX4_ARB_LOCK_EN
            cnt   <= 2'd0;
`endif
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            sel   <= sel_next;
            y     <= y_next;
            gnt   <= gnt_next;
`ifdef MUX4_ARB_LOCK_EN
            cnt   <= cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: vector table plus hand sequences (lock sequence when MUX4_ARB_LOCK_EN is defined).
module tb_mux4_rr_arbiter;

    localparam int WIDTH = 8;
    localparam int NV    = 29;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [WIDTH-1:0] i0, i1, i2, i3;
    logic             y_ready;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic [3:0]       gnt;
    logic             s1, s0;
    logic [3:0]       ack;
`ifdef MUX4_ARB_LOCK_EN
    logic [3:0]       lock;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .i0      (i0),
        .i1      (i1),
        .i2      (i2),
        .i3      (i3),
        .y_ready (y_ready),
`ifdef MUX4_ARB_LOCK_EN
        .lock    (lock),
`endif
        .y       (y),
        .y_valid (y_valid),
        .gnt     (gnt),
        .s1      (s1),
        .s0      (s0),
        .ack     (ack)
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic       y_ready;
        logic [7:0] d0;
        logic [7:0] d2;
        logic       chk_ack;
        logic [3:0] exp_ack;
        logic [7:0] exp_y;
        logic       exp_valid;
        logic [3:0] exp_gnt;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic yr,
                                input logic [7:0] d0, input logic [7:0] d2,
                                input logic ca, input logic [3:0] ea, input logic [7:0] ey,
                                input logic ev, input logic [3:0] eg, input logic [1:0] es);
        vec_t v;
        v.rst = r; v.req = rq; v.y_ready = yr; v.d0 = d0; v.d2 = d2;
        v.chk_ack = ca; v.exp_ack = ea; v.exp_y = ey;
        v.exp_valid = ev; v.exp_gnt = eg; v.exp_sel = es;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        rst     = v.rst;
        req     = v.req;
        y_ready = v.y_ready;
        i0      = v.d0;
        i1      = 8'hB1;
        i2      = v.d2;
        i3      = 8'hD3;
    endtask

    task automatic check_regs(input string tag, input logic [7:0] ey, input logic ev,
                              input logic [3:0] eg, input logic [1:0] es);
        check_output({tag, " y"},       y,        ey);
        check_output({tag, " y_valid"}, y_valid,  ev);
        check_output({tag, " gnt"},     gnt,      eg);
        check_output({tag, " sel"},     {s1, s0}, es);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
`ifdef MUX4_ARB_LOCK_EN
        lock = 4'b0000;
`endif
        //              rst  req    yr  d0     d2     chk pre    y      v  gnt    sel
        vecs[0]  = mk(1, 4'b0000, 0, 8'hA0, 8'hC2, 0, 4'h0, 8'h00, 0, 4'b0000, 2'd0);
        vecs[1]  = mk(1, 4'b1111, 1, 8'hA0, 8'hC2, 1, 4'h0, 8'h00, 0, 4'b0000, 2'd0);
        vecs[2]  = mk(0, 4'b0001, 1, 8'hA5, 8'hC2, 1, 4'h0, 8'hA5, 1, 4'b0001, 2'd0);
        vecs[3]  = mk(0, 4'b0001, 1, 8'hA5, 8'hC2, 1, 4'h1, 8'hA5, 0, 4'b0000, 2'd0);
        vecs[4]  = mk(0, 4'b0000, 1, 8'hA5, 8'hC2, 1, 4'h0, 8'hA5, 0, 4'b0000, 2'd0);
        vecs[5]  = mk(1, 4'b0000, 1, 8'hA0, 8'hC2, 1, 4'h0, 8'h00, 0, 4'b0000, 2'd0);
        vecs[6]  = mk(0, 4'b1111, 1, 8'hA0, 8'hC2, 1, 4'h0, 8'hA0, 1, 4'b0001, 2'd0);
        vecs[7]  = mk(0, 4'b1111, 1, 8'hA0, 8'hC2, 1, 4'h1, 8'hB1, 1, 4'b0010, 2'd1);
        vecs[8]  = mk(0, 4'b1111, 1, 8'hA0, 8'hC2, 1, 4'h2, 8'hC2, 1, 4'b0100, 2'd2);
        vecs[9]  = mk(0, 4'b1111, 1, 8'hA0, 8'hC2, 1, 4'h4, 8'hD3, 1, 4'b1000, 2'd3);
        vecs[10] = mk(0, 4'b1111, 1, 8'hA0, 8'hC2, 1, 4'h8, 8'hA0, 1, 4'b0001, 2'd0);
        vecs[11] = mk(0, 4'b0100, 1, 8'hA0, 8'hC2, 1, 4'h1, 8'hC2, 1, 4'b0100, 2'd2);
        vecs[12] = mk(0, 4'b1111, 0, 8'hA0, 8'h11, 1, 4'h0, 8'hC2, 1, 4'b0100, 2'd2);
        vecs[13] = mk(0, 4'b0000, 0, 8'hA0, 8'h22, 1, 4'h0, 8'hC2, 1, 4'b0100, 2'd2);
        vecs[14] = mk(0, 4'b1011, 0, 8'hA0, 8'h33, 1, 4'h0, 8'hC2, 1, 4'b0100, 2'd2);
        vecs[15] = mk(0, 4'b0100, 0, 8'hA0, 8'h44, 1, 4'h0, 8'hC2, 1, 4'b0100, 2'd2);
        vecs[16] = mk(0, 4'b1110, 0, 8'hA0, 8'h55, 1, 4'h0, 8'hC2, 1, 4'b0100, 2'd2);
        vecs[17] = mk(0, 4'b0100, 1, 8'hA0, 8'h66, 1, 4'h4, 8'hC2, 0, 4'b0000, 2'd2);
        vecs[18] = mk(0, 4'b1000, 1, 8'hA0, 8'hC2, 1, 4'h0, 8'hD3, 1, 4'b1000, 2'd3);
        vecs[19] = mk(0, 4'b1000, 1, 8'hA0, 8'hC2, 1, 4'h8, 8'hD3, 0, 4'b0000, 2'd3);
        vecs[20] = mk(0, 4'b1000, 1, 8'hA0, 8'hC2, 1, 4'h0, 8'hD3, 1, 4'b1000, 2'd3);
        vecs[21] = mk(0, 4'b1000, 1, 8'hA0, 8'hC2, 1, 4'h8, 8'hD3, 0, 4'b0000, 2'd3);
        vecs[22] = mk(0, 4'b1010, 1, 8'hA0, 8'hC2, 1, 4'h0, 8'hB1, 1, 4'b0010, 2'd1);
        vecs[23] = mk(0, 4'b1010, 0, 8'hA0, 8'hC2, 1, 4'h0, 8'hB1, 1, 4'b0010, 2'd1);
        vecs[24] = mk(1, 4'b1010, 0, 8'hA0, 8'hC2, 1, 4'h0, 8'h00, 0, 4'b0000, 2'd0);
        vecs[25] = mk(0, 4'b0000, 1, 8'hA0, 8'hC2, 1, 4'h0, 8'h00, 0, 4'b0000, 2'd0);
        vecs[26] = mk(0, 4'b1100, 1, 8'hA0, 8'hC2, 1, 4'h0, 8'hC2, 1, 4'b0100, 2'd2);
        vecs[27] = mk(0, 4'b1100, 1, 8'hA0, 8'hC2, 1, 4'h4, 8'hD3, 1, 4'b1000, 2'd3);
        vecs[28] = mk(0, 4'b0000, 1, 8'hA0, 8'hC2, 1, 4'h8, 8'hD3, 0, 4'b0000, 2'd3);

        for (int n = 0; n < NV; n++) begin
            apply_stimulus(vecs[n]);
            #1;
            if (vecs[n].chk_ack)
                check_output($sformatf("row%0d ack", n), ack, vecs[n].exp_ack);
            @(posedge clk);
            #1;
            check_regs($sformatf("row%0d", n), vecs[n].exp_y, vecs[n].exp_valid,
                       vecs[n].exp_gnt, vecs[n].exp_sel);
        end

        // Idle with ptr=0: requesters 1 and 2 compete, then the output stalls while data moves.
        i1 = 8'h5A; req = 4'b0110; y_ready = 1'b0;
        waited = 0;
        while (!y_valid && waited < 4) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check_output("seqA grant arrives", y_valid, 1'b1);
        check_regs("seqA first", 8'h5A, 1'b1, 4'b0010, 2'd1);
        i1 = 8'hFF; req = 4'b0110;
        #1;
        check_output("seqA stall ack", ack, 4'b0000);
        @(posedge clk);
        #1;
        check_regs("seqA stall", 8'h5A, 1'b1, 4'b0010, 2'd1);
        y_ready = 1'b1;
        #1;
        check_output("seqA accept ack", ack, 4'b0010);
        @(posedge clk);
        #1;
        check_regs("seqA next", 8'hC2, 1'b1, 4'b0100, 2'd2);
        req = 4'b0100;
        #1;
        check_output("seqA last ack", ack, 4'b0100);
        @(posedge clk);
        #1;
        check_regs("seqA drain", 8'hC2, 1'b0, 4'b0000, 2'd2);
        req = 4'b0000;

`ifdef MUX4_ARB_LOCK_EN
        begin
            logic [3:0] lock_exp [6];
            lock_exp[0] = 4'b0001; lock_exp[1] = 4'b0001; lock_exp[2] = 4'b0001;
            lock_exp[3] = 4'b0001; lock_exp[4] = 4'b0010; lock_exp[5] = 4'b0001;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0; req = 4'b0011; lock = 4'b0001; y_ready = 1'b1;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk);
                #1;
                check_output($sformatf("lock grant%0d", c), gnt, lock_exp[c]);
            end
            req = 4'b0000; lock = 4'b0000;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
